// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types: address/data words, response codes and word-addressing constants.
package axi_lite_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  localparam int unsigned AXI_LITE_WORD_BYTES = 4;
  localparam int unsigned AXI_LITE_ADDR_LSB   = 2;

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bundle with master and slave views.
interface axi_lite_if;

  axi_lite_pkg::addr_t araddr;
  logic                arvalid;
  logic                arready;
  axi_lite_pkg::data_t rdata;
  axi_lite_pkg::resp_t rresp;
  logic                rvalid;
  logic                rready;
  axi_lite_pkg::addr_t awaddr;
  logic                awvalid;
  logic                awready;
  axi_lite_pkg::data_t wdata;
  logic [3:0]          wstrb;
  logic                wvalid;
  logic                wready;
  axi_lite_pkg::resp_t bresp;
  logic                bvalid;
  logic                bready;

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/axi_lite_regfile.sv
// Register array with one synchronous write port and one registered read port.
// A read and a write to the same index on the same edge return the pre-write value.
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 16,
  parameter data_t       RESET_DATA = 32'h0000_0000
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_we,
  input  logic [$clog2(NUM_REGS)-1:0] i_widx,
  input  data_t                       i_wdata,
  input  logic                        i_re,
  input  logic [$clog2(NUM_REGS)-1:0] i_ridx,
  output data_t                       o_rdata
);

  data_t r_mem [NUM_REGS];
  data_t r_rdata;

  // Storage update and read capture; reset loads every word with RESET_DATA.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        r_mem[i] <= RESET_DATA;
      end
      r_rdata <= '0;
    end else begin
      if (i_we) r_mem[i_widx] <= i_wdata;
      if (i_re) r_rdata <= r_mem[i_ridx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers at BASE_ADDR + 4*i.
// Independent read and write FSMs; AW and W may arrive in either order.
// Optional macro AXI_LITE_SLAVE_SLVERR_EN: out-of-range accesses answer SLVERR
// (write dropped, read data 0) instead of wrapping the index modulo NUM_REGS.
module axi_lite_slave_regs
  import axi_lite_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 16,
  parameter addr_t       BASE_ADDR  = 32'h0000_0000,
  parameter data_t       RESET_DATA = 32'h0000_0000
) (
  input  logic       aclk,
  input  logic       areset_n,
  axi_lite_if.slave  s_axi_lite,
  output logic       wr_done
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam int unsigned HI_LSB = AXI_LITE_ADDR_LSB + IDX_W;

  typedef enum logic {W_IDLE, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;

  wr_state_e r_wstate;
  rd_state_e r_rstate;

  logic  r_awready, r_wready, r_aw_held, r_w_held, r_bvalid, r_wr_done;
  addr_t r_awaddr;
  data_t r_wdata;
  resp_t r_bresp;
  logic  r_arready, r_rvalid, r_rd_err;
  resp_t r_rresp;

  // 33-bit offsets: bit 32 is the borrow, set when the address lies below BASE_ADDR.
  logic [32:0]      w_ar_diff, w_aw_diff;
  logic [IDX_W-1:0] w_ar_idx, w_aw_idx;
  logic             w_ar_ok, w_aw_ok;
  logic             w_we, w_re;
  data_t            w_rf_rdata;
  logic             w_unused;

  assign w_ar_diff = {1'b0, s_axi_lite.araddr} - {1'b0, BASE_ADDR};
  assign w_aw_diff = {1'b0, r_awaddr} - {1'b0, BASE_ADDR};
  assign w_ar_idx  = w_ar_diff[AXI_LITE_ADDR_LSB +: IDX_W];
  assign w_aw_idx  = w_aw_diff[AXI_LITE_ADDR_LSB +: IDX_W];

`ifdef AXI_LITE_SLAVE_SLVERR_EN
  assign w_ar_ok  = (w_ar_diff[32:HI_LSB] == '0);
  assign w_aw_ok  = (w_aw_diff[32:HI_LSB] == '0);
  assign w_unused = ^{w_ar_diff[1:0], w_aw_diff[1:0], s_axi_lite.wstrb};
`else
  assign w_ar_ok  = 1'b1;
  assign w_aw_ok  = 1'b1;
  assign w_unused = ^{w_ar_diff[32:HI_LSB], w_aw_diff[32:HI_LSB], w_ar_diff[1:0],
                      w_aw_diff[1:0], s_axi_lite.wstrb};
`endif

  // Commit happens on the edge after both address and data are held.
  assign w_we = (r_wstate == W_IDLE) && r_aw_held && r_w_held && w_aw_ok;
  assign w_re = (r_rstate == R_IDLE) && s_axi_lite.arvalid && r_arready;

  axi_lite_regfile #(
    .NUM_REGS   (NUM_REGS),
    .RESET_DATA (RESET_DATA)
  ) u_regfile (
    .i_clk   (aclk),
    .i_rst_n (areset_n),
    .i_we    (w_we),
    .i_widx  (w_aw_idx),
    .i_wdata (r_wdata),
    .i_re    (w_re),
    .i_ridx  (w_ar_idx),
    .o_rdata (w_rf_rdata)
  );

  // Write FSM: collect AW and W in any order, commit, then hold B until accepted.
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b1;
      r_wready  <= 1'b1;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= OKAY;
      r_wr_done <= 1'b0;
    end else begin
      r_wr_done <= 1'b0;
      unique case (r_wstate)
        W_IDLE: begin
          if (r_aw_held && r_w_held) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_aw_ok ? OKAY : SLVERR;
            r_wr_done <= w_aw_ok;
            r_wstate  <= W_RESP;
          end else begin
            if (s_axi_lite.awvalid && r_awready) begin
              r_awaddr  <= s_axi_lite.awaddr;
              r_aw_held <= 1'b1;
              r_awready <= 1'b0;
            end
            if (s_axi_lite.wvalid && r_wready) begin
              r_wdata  <= s_axi_lite.wdata;
              r_w_held <= 1'b1;
              r_wready <= 1'b0;
            end
          end
        end
        W_RESP: begin
          if (s_axi_lite.bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
      endcase
    end
  end

  // Read FSM: accept AR, present captured data one cycle later, hold until R accepted.
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rresp   <= OKAY;
      r_rd_err  <= 1'b0;
    end else begin
      unique case (r_rstate)
        R_IDLE: begin
          if (s_axi_lite.arvalid && r_arready) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rresp   <= w_ar_ok ? OKAY : SLVERR;
            r_rd_err  <= !w_ar_ok;
            r_rstate  <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axi_lite.rready) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
      endcase
    end
  end

  assign s_axi_lite.arready = r_arready;
  assign s_axi_lite.rvalid  = r_rvalid;
  assign s_axi_lite.rresp   = r_rresp;
  assign s_axi_lite.rdata   = r_rd_err ? '0 : w_rf_rdata;
  assign s_axi_lite.awready = r_awready;
  assign s_axi_lite.wready  = r_wready;
  assign s_axi_lite.bvalid  = r_bvalid;
  assign s_axi_lite.bresp   = r_bresp;
  assign wr_done            = r_wr_done;

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Bench for axi_lite_slave_regs: directed scenarios with literal expectations, then random
// traffic, with a transaction-level model checked against every output on every cycle.
module tb_axi_lite_slave_regs;

  localparam int unsigned NR    = 16;
  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam logic [31:0] RST_D = 32'h5a5a_0001;

  logic aclk;
  logic areset_n;
  logic wr_done;
  int   checks;
  int   failures;

  axi_lite_if bus ();

  axi_lite_slave_regs #(
    .NUM_REGS   (NR),
    .BASE_ADDR  (BASE),
    .RESET_DATA (RST_D)
  ) dut (
    .aclk       (aclk),
    .areset_n   (areset_n),
    .s_axi_lite (bus),
    .wr_done    (wr_done)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Behavioural model: word store plus what each channel currently owes the master.
  logic [31:0] m_mem [NR];
  bit          m_live;
  bit          m_aw_have, m_w_have, m_b_pend, m_done, m_r_pend;
  logic [31:0] m_aw_addr, m_w_data, m_rdata;
  logic [1:0]  m_b_resp, m_rresp;

  function automatic void decode(input logic [31:0] a, output int idx, output bit ok);
    longint      off;
    logic [31:0] w;
    off = longint'({32'b0, a}) - longint'({32'b0, BASE});
    w   = a - BASE;
    idx = int'(w >> 2) % int'(NR);
`ifdef AXI_LITE_SLAVE_SLVERR_EN
    ok  = (off >= 0) && (off < 4 * longint'(NR));
`else
    ok  = (off == off);
`endif
  endfunction

  initial begin
    int idx;
    bit ok;
    m_live = 0;
    forever begin
      @(posedge aclk);
      if (!areset_n) begin
        foreach (m_mem[i]) m_mem[i] = RST_D;
        m_aw_have = 0; m_w_have = 0; m_b_pend = 0; m_done = 0; m_r_pend = 0;
        m_rdata = '0; m_rresp = 2'b00; m_b_resp = 2'b00;
        m_live = 1;
      end else if (m_live) begin
        // Read side first so a same-edge write is not visible to the read.
        if (m_r_pend) begin
          if (bus.rready) m_r_pend = 0;
        end else if (bus.arvalid) begin
          decode(bus.araddr, idx, ok);
          m_rdata  = ok ? m_mem[idx] : 32'h0;
          m_rresp  = ok ? 2'b00 : 2'b10;
          m_r_pend = 1;
        end
        m_done = 0;
        if (m_b_pend) begin
          if (bus.bready) m_b_pend = 0;
        end else if (m_aw_have && m_w_have) begin
          decode(m_aw_addr, idx, ok);
          if (ok) begin
            m_mem[idx] = m_w_data;
            m_done     = 1;
          end
          m_b_resp  = ok ? 2'b00 : 2'b10;
          m_b_pend  = 1;
          m_aw_have = 0;
          m_w_have  = 0;
        end else begin
          if (bus.awvalid && !m_aw_have) begin
            m_aw_have = 1;
            m_aw_addr = bus.awaddr;
          end
          if (bus.wvalid && !m_w_have) begin
            m_w_have = 1;
            m_w_data = bus.wdata;
          end
        end
      end
      #1;
      if (m_live) begin
        chk("arready", 32'(bus.arready), 32'(!m_r_pend));
        chk("rvalid",  32'(bus.rvalid),  32'(m_r_pend));
        chk("rdata",   bus.rdata,        m_rdata);
        chk("rresp",   32'(bus.rresp),   32'(m_rresp));
        chk("awready", 32'(bus.awready), 32'(!m_aw_have && !m_b_pend));
        chk("wready",  32'(bus.wready),  32'(!m_w_have && !m_b_pend));
        chk("bvalid",  32'(bus.bvalid),  32'(m_b_pend));
        chk("bresp",   32'(bus.bresp),   32'(m_b_resp));
        chk("wr_done", 32'(wr_done),     32'(m_done));
      end
    end
  end

  task automatic idle();
    bus.arvalid = 0; bus.awvalid = 0; bus.wvalid = 0;
    bus.araddr = '0; bus.awaddr = '0; bus.wdata = '0; bus.wstrb = 4'hf;
    bus.rready = 1; bus.bready = 1;
  endtask

  // Same-cycle AW+W, then commit and B handshake (bready must be 1).
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.awvalid = 1; bus.awaddr = a; bus.wvalid = 1; bus.wdata = d;
    step();
    bus.awvalid = 0; bus.wvalid = 0;
    step();
    step();
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    bus.arvalid = 1; bus.araddr = a;
    step();
    bus.arvalid = 0;
    d = bus.rdata;
    r = bus.rresp;
    step();
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic [1:0]  held_resp;
    checks = 0;
    failures = 0;
    areset_n = 0;
    idle();
    repeat (3) step();
    chk("rst_arready", 32'(bus.arready), 32'd1);
    chk("rst_awready", 32'(bus.awready), 32'd1);
    chk("rst_wready",  32'(bus.wready),  32'd1);
    chk("rst_bvalid",  32'(bus.bvalid),  32'd0);
    chk("rst_rvalid",  32'(bus.rvalid),  32'd0);
    chk("rst_rdata",   bus.rdata,        32'd0);
    chk("rst_wr_done", 32'(wr_done),     32'd0);
    areset_n = 1;

    // AW then W next cycle.
    bus.awvalid = 1; bus.awaddr = BASE + 4;
    step();
    bus.awvalid = 0; bus.wvalid = 1; bus.wdata = 32'hece00593;
    step();
    bus.wvalid = 0;
    chk("b_not_early", 32'(bus.bvalid), 32'd0);
    step();
    chk("b_latency", 32'(bus.bvalid), 32'd1);
    chk("b_okay",    32'(bus.bresp),  32'd0);
    chk("done_1",    32'(wr_done),    32'd1);
    step();
    chk("b_clear",   32'(bus.bvalid), 32'd0);
    chk("done_once", 32'(wr_done),    32'd0);
    chk("aw_reopen", 32'(bus.awready), 32'd1);

    bus.arvalid = 1; bus.araddr = BASE + 4;
    step();
    bus.arvalid = 0;
    chk("r_latency", 32'(bus.rvalid), 32'd1);
    chk("r_data4",   bus.rdata,       32'hece00593);
    chk("r_okay",    32'(bus.rresp),  32'd0);
    step();
    chk("r_clear",   32'(bus.rvalid), 32'd0);

    // W before AW at 8, then same-cycle at 12.
    bus.wvalid = 1; bus.wdata = 32'h1234_5678;
    step();
    bus.wvalid = 0; bus.awvalid = 1; bus.awaddr = BASE + 8;
    step();
    bus.awvalid = 0;
    step();
    step();
    wr(BASE + 12, 32'hcafe_f00d);
    rd(BASE + 8, d, r);
    chk("w_first_8", d, 32'h1234_5678);
    rd(BASE + 12, d, r);
    chk("same_cyc_12", d, 32'hcafe_f00d);

    // Back-pressure on B and R.
    bus.bready = 0;
    bus.awvalid = 1; bus.wvalid = 1; bus.awaddr = BASE + 16; bus.wdata = 32'h0000_beef;
    step();
    bus.awvalid = 0; bus.wvalid = 0;
    step();
    held_resp = bus.bresp;
    for (int i = 0; i < 5; i++) begin
      chk("b_hold_valid", 32'(bus.bvalid),  32'd1);
      chk("b_hold_resp",  32'(bus.bresp),   32'(held_resp));
      chk("b_hold_awrdy", 32'(bus.awready), 32'd0);
      chk("b_hold_wrdy",  32'(bus.wready),  32'd0);
      step();
    end
    bus.bready = 1;
    step();
    chk("b_release", 32'(bus.bvalid), 32'd0);
    bus.rready = 0; bus.arvalid = 1; bus.araddr = BASE + 16;
    step();
    bus.arvalid = 0;
    for (int i = 0; i < 5; i++) begin
      chk("r_hold_valid", 32'(bus.rvalid), 32'd1);
      chk("r_hold_data",  bus.rdata,       32'h0000_beef);
      step();
    end
    bus.rready = 1;
    step();
    chk("r_release", 32'(bus.rvalid), 32'd0);

    // Commit and AR to the same index on the same edge.
    bus.awvalid = 1; bus.wvalid = 1; bus.awaddr = BASE + 4; bus.wdata = 32'h7777_1111;
    step();
    bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 1; bus.araddr = BASE + 4;
    step();
    bus.arvalid = 0;
    chk("collide_old", bus.rdata, 32'hece00593);
    chk("collide_done", 32'(wr_done), 32'd1);
    step();
    rd(BASE + 4, d, r);
    chk("collide_new", d, 32'h7777_1111);

    // Out-of-range read.
    wr(BASE, 32'h0bad_f00d);
    rd(BASE + 4 * NR, d, r);
`ifdef AXI_LITE_SLAVE_SLVERR_EN
    chk("oor_rdata", d, 32'h0);
    chk("oor_rresp", 32'(r), 32'd2);
`else
    chk("wrap_rdata", d, 32'h0bad_f00d);
    chk("wrap_rresp", 32'(r), 32'd0);
`endif

    // Reset while a response is pending.
    bus.bready = 0;
    bus.awvalid = 1; bus.wvalid = 1; bus.awaddr = BASE + 4; bus.wdata = 32'h1357_9bdf;
    step();
    bus.awvalid = 0; bus.wvalid = 0;
    step();
    chk("pre_rst_bvalid", 32'(bus.bvalid), 32'd1);
    areset_n = 0;
    step();
    chk("rst_abort_bvalid",  32'(bus.bvalid),  32'd0);
    chk("rst_abort_awready", 32'(bus.awready), 32'd1);
    areset_n = 1;
    bus.bready = 1;
    rd(BASE + 4, d, r);
    chk("rst_reg1", d, RST_D);

    // Random traffic, including occasional resets and out-of-range addresses.
    for (int c = 0; c < 1500; c++) begin
      areset_n    = ($urandom_range(0, 199) != 0);
      bus.arvalid = $urandom_range(0, 1) == 1;
      bus.araddr  = BASE - 16 + $urandom_range(0, 4 * NR + 31);
      bus.awvalid = $urandom_range(0, 2) == 0;
      bus.awaddr  = BASE - 16 + $urandom_range(0, 4 * NR + 31);
      bus.wvalid  = $urandom_range(0, 2) == 0;
      bus.wdata   = $urandom;
      bus.wstrb   = 4'($urandom_range(0, 15));
      bus.rready  = $urandom_range(0, 3) != 0;
      bus.bready  = $urandom_range(0, 3) != 0;
      step();
    end
    areset_n = 1;
    idle();
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
